// File: rtl/adc_sample_ctrl_pkg.sv
// Shared constants for the ADC sampling controller: register map, bit positions, FSM encoding.
package adc_sample_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_MEAS   = 2'd3;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_CONT_BIT  = 1;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_DV_BIT   = 1;
    localparam int unsigned STAT_TO_BIT   = 2;
    localparam int unsigned STAT_OV_BIT   = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_TRIG = 2'd1;
    localparam state_t ST_WAIT = 2'd2;

endpackage

// File: rtl/adc_sample_ctrl_timer.sv
// Periodic down-counter; expire_o pulses once every period_i cycles while enabled.
module adc_period_timer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] period_i,
    input  logic                  reload_i,
    output logic                  expire_o
);

    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        expire_o = 1'b0;
        cnt_d    = cnt_q - DATA_WIDTH'(1);
        // While disabled the counter tracks PERIOD so the next enable starts a full interval.
        if (!enable_i || reload_i || cnt_q == '0) begin
            cnt_d = period_i;
        end else if (cnt_q == DATA_WIDTH'(1)) begin
            expire_o = 1'b1;
            cnt_d    = period_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_sample_ctrl.sv
// ADC trigger/measurement initiator with a single-cycle register port and a level interrupt.
module adc_sample_ctrl
    import adc_sample_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel_i,
    input  logic                  write_i,
    input  logic [1:0]            addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  adc_trigger_o,
    input  logic                  adc_valid_i,
    input  logic [DATA_WIDTH-1:0] adc_data_i,
    output logic                  irq_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  pending_q, pending_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic                  cont_q, cont_d;
    logic [DATA_WIDTH-1:0] period_q, period_d;
    logic                  reload_q, reload_d;
    logic [DATA_WIDTH-1:0] meas_q, meas_d;
    logic                  dv_q, dv_d, to_q, to_d, ov_q, ov_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  irq_q, irq_d;

    logic                  wr_en, rd_en, start_wr, busy, capture, timeout, expire, drop;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_en    = sel_i & write_i;
    assign rd_en    = sel_i & ~write_i;
    assign start_wr = wr_en && (addr_i == ADDR_CTRL) && wdata_i[CTRL_START_BIT];
    assign busy     = (state_q != ST_IDLE);
    assign capture  = (state_q == ST_WAIT) && adc_valid_i;
    assign timeout  = (state_q == ST_WAIT) && !adc_valid_i && (to_cnt_q == TO_LAST);
    assign drop     = expire && (busy || pending_q);

    adc_period_timer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .enable_i (cont_q && (period_q != '0)),
        .period_i (period_q),
        .reload_i (reload_q),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        to_cnt_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q || start_wr || expire) begin
                    state_d   = ST_TRIG;
                    pending_d = 1'b0;
                end
            end
            ST_TRIG: state_d = ST_WAIT;
            ST_WAIT: begin
                if (capture || timeout) begin
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (busy && start_wr) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        cont_d   = cont_q;
        period_d = period_q;
        reload_d = 1'b0;
        meas_d   = capture ? adc_data_i : meas_q;
        dv_d     = dv_q;
        to_d     = to_q;
        ov_d     = ov_q;
        if (wr_en && addr_i == ADDR_CTRL) begin
            cont_d = wdata_i[CTRL_CONT_BIT];
        end
        if (wr_en && addr_i == ADDR_PERIOD) begin
            period_d = wdata_i;
            reload_d = 1'b1;
        end
        if (wr_en && addr_i == ADDR_STATUS) begin
            dv_d = dv_q & ~wdata_i[STAT_DV_BIT];
            to_d = to_q & ~wdata_i[STAT_TO_BIT];
            ov_d = ov_q & ~wdata_i[STAT_OV_BIT];
        end
        if (rd_en && addr_i == ADDR_MEAS) begin
            dv_d = 1'b0;
        end
        // Hardware sets come last so they win over software clears in the same cycle.
        if (capture) begin
            dv_d = 1'b1;
            if (dv_q) begin
                ov_d = 1'b1;
            end
        end
        if (timeout) begin
            to_d = 1'b1;
        end
        if (drop) begin
            ov_d = 1'b1;
        end
        irq_d = dv_q | to_q | ov_q;
    end

    always_comb begin
        rd_word = '0;
        case (addr_i)
            ADDR_CTRL:   rd_word[CTRL_CONT_BIT] = cont_q;
            ADDR_PERIOD: rd_word = period_q;
            ADDR_STATUS: begin
                rd_word[STAT_BUSY_BIT] = busy;
                rd_word[STAT_DV_BIT]   = dv_q;
                rd_word[STAT_TO_BIT]   = to_q;
                rd_word[STAT_OV_BIT]   = ov_q;
            end
            default:     rd_word = meas_q;
        endcase
        rdata_d = rd_en ? rd_word : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            to_cnt_q  <= '0;
            cont_q    <= 1'b0;
            period_q  <= '0;
            reload_q  <= 1'b0;
            meas_q    <= '0;
            dv_q      <= 1'b0;
            to_q      <= 1'b0;
            ov_q      <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            to_cnt_q  <= to_cnt_d;
            cont_q    <= cont_d;
            period_q  <= period_d;
            reload_q  <= reload_d;
            meas_q    <= meas_d;
            dv_q      <= dv_d;
            to_q      <= to_d;
            ov_q      <= ov_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign adc_trigger_o = (state_q == ST_TRIG);
    assign rdata_o       = rdata_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Scoreboard bench: stimulus queues expected read data and trigger cycles, a monitor checks them.
module tb_adc_sample_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PERIOD = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_MEAS   = 2'd3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sel = 1'b0;
    logic          wr = 1'b0;
    logic [1:0]    addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          trig;
    logic          irq;
    logic          m_valid = 1'b0;
    logic          man_valid = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] man_data = '0;
    logic          adc_valid;
    logic [DW-1:0] adc_data;

    assign adc_valid = m_valid | man_valid;
    assign adc_data  = man_valid ? man_data : m_data;

    typedef struct {
        logic [DW-1:0] val;
        string         name;
    } rd_exp_t;

    rd_exp_t       rd_q[$];
    int            trig_q[$];
    rd_exp_t       mon_e;
    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            n;
    int            adc_delay = 0;
    int            adc_cd = 0;
    logic [DW-1:0] adc_next = '0;
    logic          rd_seen = 1'b0;

    adc_sample_ctrl #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sel_i         (sel),
        .write_i       (wr),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .rdata_o       (rdata),
        .adc_trigger_o (trig),
        .adc_valid_i   (adc_valid),
        .adc_data_i    (adc_data),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_seen <= sel && !wr;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [DW-1:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick(1);
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [DW-1:0] e, input string name);
        rd_exp_t x;
        x.val = e;
        x.name = name;
        rd_q.push_back(x);
        sel = 1'b1; wr = 1'b0; addr = a;
        tick(1);
        sel = 1'b0;
    endtask

    // Monitor: read data arrives the cycle after the access; each trigger must match a queued cycle.
    initial forever begin
        @(negedge clk);
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_read: rdata 0x%0h, no read queued", rdata);
            end else begin
                mon_e = rd_q.pop_front();
                check(mon_e.name, rdata, mon_e.val);
            end
        end
        if (trig === 1'b1) begin
            if (trig_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_trigger: trigger at cycle %0d, none expected", cyc);
            end else begin
                check("trigger_cycle", DW'(cyc), DW'(trig_q.pop_front()));
            end
        end
    end

    // ADC model: answers adc_delay cycles after a trigger with an incrementing data value.
    initial forever begin
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        if (adc_cd > 0) begin
            adc_cd--;
            if (adc_cd == 0) begin
                m_valid  = 1'b1;
                m_data   = adc_next;
                adc_next = adc_next + 1;
            end
        end
        if (trig === 1'b1 && adc_delay > 0) adc_cd = adc_delay;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        reset = 1'b0;
        check("rst_rdata", rdata, '0);
        check("rst_trigger", DW'(trig), '0);
        check("rst_irq", DW'(irq), '0);
        bus_read(A_CTRL, 32'h0, "rst_ctrl");
        bus_read(A_PERIOD, 32'h0, "rst_period");
        bus_read(A_STATUS, 32'h0, "rst_status");
        bus_read(A_MEAS, 32'h0, "rst_meas");

        // Single START conversion, ADC answers 3 cycles after the trigger.
        adc_delay = 3; adc_next = 32'hABC;
        n = cyc; trig_q.push_back(n + 1);
        bus_write(A_CTRL, 32'h1);
        tick(5);
        check("t1_irq_set", DW'(irq), 32'h1);
        bus_read(A_STATUS, 32'h2, "t1_status");
        bus_read(A_MEAS, 32'hABC, "t1_meas");
        tick(1);
        check("t1_irq_clr", DW'(irq), 32'h0);
        bus_read(A_STATUS, 32'h0, "t1_status_clr");

        // Continuous mode, PERIOD 20, ADC answers after 4 cycles.
        adc_delay = 4; adc_next = 32'h100;
        bus_write(A_PERIOD, 32'd20);
        n = cyc; trig_q.push_back(n + 21); trig_q.push_back(n + 41);
        bus_write(A_CTRL, 32'h2);
        bus_read(A_CTRL, 32'h2, "t2_ctrl");
        bus_read(A_PERIOD, 32'd20, "t2_period");
        tick(44);
        bus_read(A_STATUS, 32'hA, "t2_status_ovr");
        bus_write(A_CTRL, 32'h0);
        bus_read(A_MEAS, 32'h101, "t2_meas");
        bus_write(A_STATUS, 32'h8);
        bus_read(A_STATUS, 32'h0, "t2_ovr_clr");

        // Timeout after 16 WAIT cycles with no ADC answer.
        adc_delay = 0;
        n = cyc; trig_q.push_back(n + 1);
        bus_write(A_CTRL, 32'h1);
        tick(16);
        bus_read(A_STATUS, 32'h1, "t3_busy_last_cycle");
        bus_read(A_STATUS, 32'h4, "t3_timeout");
        bus_write(A_STATUS, 32'h4);
        bus_read(A_STATUS, 32'h0, "t3_to_clr");
        bus_read(A_MEAS, 32'h101, "t3_meas_keep");

        // adc_valid in the final WAIT cycle is a capture, not a timeout.
        n = cyc; trig_q.push_back(n + 1);
        bus_write(A_CTRL, 32'h1);
        tick(16);
        man_valid = 1'b1; man_data = 32'h333;
        tick(1);
        man_valid = 1'b0;
        bus_read(A_STATUS, 32'h2, "t3_final_cycle_capture");
        bus_read(A_MEAS, 32'h333, "t3_final_meas");

        // adc_valid ignored in IDLE and TRIG; capture concurrent with a MEASUREMENT read.
        man_valid = 1'b1; man_data = 32'h555;
        tick(1);
        man_valid = 1'b0;
        n = cyc; trig_q.push_back(n + 1);
        bus_write(A_CTRL, 32'h1);
        man_valid = 1'b1; man_data = 32'h666;
        tick(1);
        man_valid = 1'b0;
        bus_read(A_STATUS, 32'h1, "t4_no_flags");
        bus_read(A_MEAS, 32'h333, "t4_meas_keep");
        man_valid = 1'b1; man_data = 32'h777;
        bus_read(A_MEAS, 32'h333, "t4_meas_old_on_capture");
        man_valid = 1'b0;
        bus_read(A_STATUS, 32'h2, "t4_dv_set_wins");
        bus_read(A_MEAS, 32'h777, "t4_meas_new");

        // PERIOD 4 with 10-cycle conversions: expiries while busy are dropped.
        adc_delay = 10; adc_next = 32'h200;
        bus_write(A_PERIOD, 32'd4);
        n = cyc; trig_q.push_back(n + 5); trig_q.push_back(n + 17);
        bus_write(A_CTRL, 32'h2);
        tick(17);
        bus_write(A_CTRL, 32'h0);
        tick(10);
        bus_read(A_STATUS, 32'hA, "t5_overrun");
        bus_read(A_MEAS, 32'h201, "t5_meas");

        // Reset during WAIT, then a late adc_valid.
        adc_delay = 0;
        n = cyc; trig_q.push_back(n + 1);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_MEAS, 32'h201, "t6_pre_meas");
        tick(1);
        check("t6_pre_irq", DW'(irq), 32'h1);
        reset = 1'b1;
        #1;
        check("t6_rst_rdata", rdata, '0);
        check("t6_rst_trigger", DW'(trig), '0);
        check("t6_rst_irq", DW'(irq), '0);
        tick(2);
        reset = 1'b0;
        man_valid = 1'b1; man_data = 32'hDEAD;
        tick(1);
        man_valid = 1'b0;
        bus_read(A_STATUS, 32'h0, "t6_status");
        bus_read(A_MEAS, 32'h0, "t6_meas");
        bus_read(A_PERIOD, 32'h0, "t6_period");
        tick(2);
        check("t6_irq_after", DW'(irq), 32'h0);

        tick(2);
        check("trig_queue_drained", DW'(trig_q.size()), '0);
        check("read_queue_drained", DW'(rd_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
